pipe_skid_stage: RTL and testbench

//  Elastic pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.

---
 rtl/pipe_skid_stage.sv | 119 +++++++++++
 tb/tb_pipe_skid_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a valid/ready handshake, a 2-entry skid buffer and flush.
// in_ready, out_valid and occupancy come only from registered state. This keeps any
// combinational path from out_ready to in_ready, or from in_* to out_*, out of this stage.
module pipe_skid_stage #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic in_fire;
    logic out_fire;

    // Decode the handshake outputs and the occupancy from the registered state only.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
            StOne: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            StTwo: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    // Next state and data: flush wins over the normal transitions. A flush clears validity
    // only, so the data registers keep whatever they held.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // State and data registers with a synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage. A queue model of the stage is compared with the DUT on every cycle.
// Directed sequences also check hand-computed literal values.
module tb_pipe_skid_stage;

    localparam int unsigned  W     = 32;
    localparam logic [W-1:0] RSTV  = 32'hDEAD_BEEF;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int total;
    int bad;
    bit mon_en;

    // Model: the ordered list of entries the stage currently holds.
    logic [W-1:0] mq[$];

    pipe_skid_stage #(
        .WIDTH       (W),
        .RESET_VALUE (RSTV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: the stage acts as a FIFO of depth 2. It pops before it pushes.
    always @(posedge clk) begin
        automatic bit can_in  = (mq.size() < 2);
        automatic bit can_out = (mq.size() > 0);
        automatic bit ifire   = in_valid && can_in;
        automatic bit ofire   = out_ready && can_out;
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(in_data);
        end
    end

    // Compare the DUT with the model away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mdl out_valid", W'(out_valid), W'(mq.size() != 0));
            chk("mdl in_ready", W'(in_ready), W'(mq.size() < 2));
            chk("mdl occupancy", W'(occupancy), W'(mq.size()));
            chk("inv in_ready", W'(in_ready), W'(occupancy != 2'd2));
            if (mq.size() != 0) chk("mdl out_data", out_data, mq[0]);
        end
    end

    // Drive one cycle of inputs just after a negedge, then wait for the next negedge.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                        input logic fl, input logic rst);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clk);
    endtask

    task automatic lit(input string tag, input logic ov, input logic ir, input logic [1:0] occ,
                       input logic chk_data, input logic [W-1:0] d);
        chk({tag, " out_valid"}, W'(out_valid), W'(ov));
        chk({tag, " in_ready"}, W'(in_ready), W'(ir));
        chk({tag, " occupancy"}, W'(occupancy), W'(occ));
        if (chk_data) chk({tag, " out_data"}, out_data, d);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; reset = 1'b0;
        @(negedge clk);

        // Reset state.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        lit("reset", 1'b0, 1'b1, 2'd0, 1'b1, RSTV);

        // T1: streaming at full rate with a one-cycle latency.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
            lit("T1", 1'b1, 1'b1, 2'd1, 1'b1, W'(i));
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        lit("T1 drain", 1'b0, 1'b1, 2'd0, 1'b0, '0);

        // T2: backpressure fills the skid entry, then the stage drains in order.
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        lit("T2 one", 1'b1, 1'b1, 2'd1, 1'b1, 32'hA);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        lit("T2 two", 1'b1, 1'b0, 2'd2, 1'b1, 32'hA);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        lit("T2 hold", 1'b1, 1'b0, 2'd2, 1'b1, 32'hA);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        lit("T2 rel1", 1'b1, 1'b1, 2'd1, 1'b1, 32'hB);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        lit("T2 rel2", 1'b0, 1'b1, 2'd0, 1'b0, '0);

        // T4: a flush from TWO while in_valid is high. Then a flush from ONE that
        // discards the entry accepted in the flush cycle.
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        lit("T4 two", 1'b1, 1'b0, 2'd2, 1'b1, 32'h11);
        step(1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
        lit("T4 flush2", 1'b0, 1'b1, 2'd0, 1'b0, '0);
        step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h55, 1'b1, 1'b1, 1'b0);
        lit("T4 flush1", 1'b0, 1'b1, 2'd0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            lit("T4 idle", 1'b0, 1'b1, 2'd0, 1'b0, '0);
        end

        // T5: a reset while the stage is full.
        step(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        lit("T5 two", 1'b1, 1'b0, 2'd2, 1'b1, 32'h66);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        lit("T5 reset", 1'b0, 1'b1, 2'd0, 1'b1, RSTV);

        // T6: simultaneous in_fire and out_fire while in ONE.
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 32'h100 + W'(k), 1'b1, 1'b0, 1'b0);
            lit("T6", 1'b1, 1'b1, 2'd1, 1'b1, 32'h100 + W'(k));
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // T3: random handshakes, checked by the model every cycle.
        for (int n = 0; n < 10000; n++) begin
            step(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), 1'b0, 1'b0);
        end
        for (int n = 0; n < 4; n++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        lit("T3 end", 1'b0, 1'b1, 2'd0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
